scan_decoder: RTL and testbench

//  Registered, parametrised N-to-2^N one-hot decoder with enable, plus an

---
 rtl/scan_decoder.sv | 68 ++++++
 tb/tb_scan_decoder.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/scan_decoder.sv
// Registered one-hot decoder with enable and an auto-scan mode.
// Scan mode walks the select through every line, holding each for DWELL cycles.
module scan_decoder #(
  parameter int ADDR_WIDTH = 2,
  parameter int DWELL      = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic                       mode,
  input  logic                       load,
  input  logic [ADDR_WIDTH-1:0]      address,
  output logic [2**ADDR_WIDTH-1:0]   out,
  output logic [ADDR_WIDTH-1:0]      cur_addr,
  output logic                       wrap
);

  localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0] DMAX = CW'(DWELL - 1);

  logic [CW-1:0]         dwell_cnt;
  logic                  active;

  logic [ADDR_WIDTH-1:0] addr_nx;
  logic [CW-1:0]         cnt_nx;
  logic                  wrap_nx;

  // next pointer / dwell count: direct load, scan load, advance or pause
  always_comb begin
    addr_nx = cur_addr;
    cnt_nx  = dwell_cnt;
    wrap_nx = 1'b0;
    if (!mode || load) begin
      addr_nx = address;
      cnt_nx  = '0;
    end else if (enable) begin
      if (dwell_cnt == DMAX) begin
        cnt_nx  = '0;
        addr_nx = cur_addr + 1'b1;
        wrap_nx = &cur_addr;
      end else begin
        cnt_nx = dwell_cnt + CW'(1);
      end
    end
  end

  // state registers, synchronous reset clears everything
  always_ff @(posedge clk) begin
    if (reset) begin
      cur_addr  <= '0;
      dwell_cnt <= '0;
      active    <= 1'b0;
      wrap      <= 1'b0;
    end else begin
      cur_addr  <= addr_nx;
      dwell_cnt <= cnt_nx;
      active    <= enable;
      wrap      <= wrap_nx;
    end
  end

  // one-hot select decoded purely from registered state
  always_comb begin
    out = '0;
    if (active) out[cur_addr] = 1'b1;
  end

endmodule

// File: tb/tb_scan_decoder.sv
// Self-checking bench for scan_decoder: two instances (8-line direct/fast
// scan and 4-line dwell-3 scan) driven together against a reference model.
module tb_scan_decoder;

  logic       clk = 1'b0;
  logic       reset, enable, mode, load;
  logic [2:0] address;

  logic [7:0] out_a;
  logic [2:0] cur_a;
  logic       wrap_a;
  logic [3:0] out_b;
  logic [1:0] cur_b;
  logic       wrap_b;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  scan_decoder #(.ADDR_WIDTH(3), .DWELL(1)) u_a (
    .clk(clk), .reset(reset), .enable(enable), .mode(mode), .load(load),
    .address(address), .out(out_a), .cur_addr(cur_a), .wrap(wrap_a)
  );

  scan_decoder #(.ADDR_WIDTH(2), .DWELL(3)) u_b (
    .clk(clk), .reset(reset), .enable(enable), .mode(mode), .load(load),
    .address(address[1:0]), .out(out_b), .cur_addr(cur_b), .wrap(wrap_b)
  );

  // Reference: which line is selected and how many enabled scan
  // cycles have been spent on it so far.
  typedef struct {
    int line;
    int spent;
    bit lit;
    bit wrapped;
  } ref_t;

  ref_t ma, mb;

  function automatic ref_t ref_step(ref_t s, int nout, int dwell,
                                    bit rst, bit en, bit md, bit ld, int a);
    ref_t n;
    n = s;
    n.wrapped = 0;
    if (rst) begin
      n.line = 0; n.spent = 0; n.lit = 0;
      return n;
    end
    n.lit = en;
    if (!md || ld) begin
      n.line = a % nout;
      n.spent = 0;
    end else if (en) begin
      n.spent = s.spent + 1;
      if (n.spent == dwell) begin
        n.spent = 0;
        n.line = (s.line + 1) % nout;
        n.wrapped = (n.line == 0);
      end
    end
    return n;
  endfunction

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cmp_all();
    int ea, eb;
    ea = ma.lit ? (1 << ma.line) : 0;
    eb = mb.lit ? (1 << mb.line) : 0;
    check("a_out", 32'(out_a), 32'(ea));
    check("a_cur", 32'(cur_a), 32'(ma.line));
    check("a_wrap", 32'(wrap_a), 32'(ma.wrapped));
    check("b_out", 32'(out_b), 32'(eb));
    check("b_cur", 32'(cur_b), 32'(mb.line));
    check("b_wrap", 32'(wrap_b), 32'(mb.wrapped));
    check("a_onehot", 32'($countones(out_a) <= 1), 32'd1);
  endtask

  task automatic cyc(input bit rst, input bit en, input bit md,
                     input bit ld, input int a);
    reset = rst; enable = en; mode = md; load = ld;
    address = 3'(a);
    @(posedge clk);
    ma = ref_step(ma, 8, 1, rst, en, md, ld, a);
    mb = ref_step(mb, 4, 3, rst, en, md, ld, a % 4);
    #1;
    cmp_all();
  endtask

  initial begin
    int seq3 [9];
    seq3 = '{2, 2, 2, 3, 3, 3, 0, 0, 0};
    ma = '{0, 0, 0, 0};
    mb = '{0, 0, 0, 0};
    reset = 1; enable = 0; mode = 0; load = 0; address = 0;

    // 1: reset with random inputs
    for (int i = 0; i < 2; i++) begin
      cyc(1, 1'($urandom), 1'($urandom), 1'($urandom), int'($urandom_range(7)));
      check("rst_out", 32'(out_a), 32'd0);
      check("rst_cur", 32'(cur_a), 32'd0);
    end

    // 2: direct sweep, then disabled
    for (int k = 0; k < 8; k++) begin
      cyc(0, 1, 0, 1'($urandom), k);
      check("dir_out", 32'(out_a), 32'd1 << k);
    end
    cyc(0, 0, 0, 0, 5);
    check("dir_off", 32'(out_a), 32'd0);

    // 3: scan with dwell 3 from line 2
    cyc(0, 1, 1, 1, 2);
    check("scan_cur0", 32'(cur_b), 32'(seq3[0]));
    for (int i = 1; i < 9; i++) begin
      cyc(0, 1, 1, 0, int'($urandom_range(7)));
      check("scan_cur", 32'(cur_b), 32'(seq3[i]));
      check("scan_wrap", 32'(wrap_b), 32'(i == 6));
    end
    check("scan_out", 32'(out_b), 32'b0001);

    // 4: pause mid-dwell, remaining count honoured on resume
    cyc(0, 1, 1, 1, 2);
    cyc(0, 1, 1, 0, 0);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 1, 0, int'($urandom_range(7)));
      check("pause_out", 32'(out_b), 32'd0);
      check("pause_cur", 32'(cur_b), 32'd2);
    end
    cyc(0, 1, 1, 0, 0);
    check("resume_hold", 32'(cur_b), 32'd2);
    cyc(0, 1, 1, 0, 0);
    check("resume_adv", 32'(cur_b), 32'd3);

    // 5: load wins over an imminent wrap
    cyc(0, 1, 1, 0, 0);
    cyc(0, 1, 1, 0, 0);
    cyc(0, 1, 1, 1, 1);
    check("coll_cur", 32'(cur_b), 32'd1);
    check("coll_wrap", 32'(wrap_b), 32'd0);

    // 6: reset mid-dwell, then direct decode
    cyc(0, 1, 1, 0, 0);
    cyc(1, 1, 1, 0, 0);
    check("mrst_out", 32'(out_b), 32'd0);
    check("mrst_cur", 32'(cur_b), 32'd0);
    cyc(0, 1, 0, 0, 3);
    check("flip_out", 32'(out_b), 32'b1000);
    cyc(0, 1, 1, 0, 0);
    check("flip_scan", 32'(cur_b), 32'd3);

    // randomized traffic, mostly scanning
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(31) == 0), ($urandom_range(3) != 0),
          ($urandom_range(3) != 0), ($urandom_range(7) == 0),
          int'($urandom_range(7)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
